instr_fetch_unit: RTL and testbench

//  Instruction fetch stage. Sits upstream of the Decodeur.
//  - Generates word-aligned fetch addresses and issues them to the instruction memory over a req/gnt/rvalid interface.
//  - Buffers returned words in a prefetch FIFO and presents {instr, instr_pc} to the decoder with a valid/ready handshake.
//  - On a redirect (taken jump/branch from the controller/PC path), flushes the FIFO and discards stale in-flight responses.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 57 +++++
 rtl/instr_fetch_unit.sv | 115 +++++++++++
 tb/tb_instr_fetch_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return pc & ~PC_W'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; the head is read straight from storage flops and
// forced to zero while empty so downstream never sees stale or unknown data.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter type T     = fetch_entry_t,
    parameter int  DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  T                           push_data,
    input  logic                       pop,
    output T                           head,
    output logic                       head_vld,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign do_push = push && ((count != FULL) || do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head_vld = (count != '0);
    assign head     = head_vld ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: credit-limited request generation, in-order response
// tracking, redirect flush with discard of stale responses, output buffer.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               instr_ready
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] CREDIT = (CNT_W + 1)'(DEPTH);

    logic [PC_W-1:0]  fetch_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] out_next;
    logic [CNT_W-1:0] drop;
    logic [CNT_W-1:0] buf_count;
    logic [CNT_W-1:0] pcq_count;
    logic [CNT_W:0]   in_use;
    logic             issue;
    logic             rsp;
    logic             keep;
    logic [PC_W-1:0]  pcq_head;
    logic             pcq_vld;
    fetch_entry_t     buf_push;
    fetch_entry_t     buf_head;

    // Buffered plus in-flight words never exceed the buffer, so responses always fit.
    assign in_use    = {1'b0, buf_count} + {1'b0, outstanding};
    assign imem_req  = !reset && !redirect && (in_use < CREDIT);
    assign imem_addr = fetch_pc;
    assign issue     = imem_req && imem_gnt;
    assign rsp       = imem_rvalid && (outstanding != '0);
    assign keep      = rsp && (drop == '0) && !redirect && pcq_vld;

    always_comb begin
        out_next = outstanding;
        if (issue && !rsp)      out_next = outstanding + 1'b1;
        else if (rsp && !issue) out_next = outstanding - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= out_next;
            if (redirect) begin
                // Everything still in flight belongs to the old stream.
                fetch_pc <= align_pc(redirect_pc);
                drop     <= out_next;
            end else begin
                if (issue) fetch_pc <= fetch_pc + 32'd4;
                if (rsp && (drop != '0)) drop <= drop - 1'b1;
            end
        end
    end

    fetch_fifo #(
        .T     (logic [PC_W-1:0]),
        .DEPTH (DEPTH)
    ) u_pc_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (issue),
        .push_data (fetch_pc),
        .pop       (keep),
        .head      (pcq_head),
        .head_vld  (pcq_vld),
        .count     (pcq_count)
    );

    assign buf_push = '{pc: pcq_head, instr: imem_rdata};

    fetch_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (DEPTH)
    ) u_out_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (keep),
        .push_data (buf_push),
        .pop       (instr_ready && !redirect),
        .head      (buf_head),
        .head_vld  (instr_valid),
        .count     (buf_count)
    );

    assign instr    = buf_head.instr;
    assign instr_pc = buf_head.pc;

    a_no_orphan_rsp : assert property (@(posedge clk) disable iff (reset)
        imem_rvalid |-> (outstanding != '0));

    a_pcq_tracks : assert property (@(posedge clk) disable iff (reset)
        pcq_count == (outstanding - drop));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a one-cycle-latency memory model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          rcyc = 0;
    bit          resp_en = 1'b1;
    logic        last_req;
    logic        last_valid;
    logic [31:0] last_addr;
    logic [31:0] pend[$];
    logic [31:0] iss_addr[$];
    logic [31:0] iss_cyc[$];
    logic [31:0] del_pc[$];
    logic [31:0] del_ins[$];
    logic [31:0] del_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qv(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 'x;
    endfunction

    task automatic clear_logs();
        iss_addr.delete();
        iss_cyc.delete();
        del_pc.delete();
        del_ins.delete();
        del_cyc.delete();
        cyc = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        redirect = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        resp_en = 1'b1;
        pend.delete();
        @(posedge clk);
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
    endtask

    task automatic step(input logic g, input logic r, input logic rd, input logic [31:0] rpc);
        @(negedge clk);
        reset = 1'b0;
        imem_gnt = g;
        instr_ready = r;
        redirect = rd;
        redirect_pc = rpc;
        if (resp_en && pend.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata = pend.pop_front() | 32'hA000_0000;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata = '0;
        end
        #1;
        last_req = imem_req;
        last_addr = imem_addr;
        last_valid = instr_valid;
        if (imem_req && imem_gnt) begin
            pend.push_back(imem_addr);
            iss_addr.push_back(imem_addr);
            iss_cyc.push_back(32'(cyc));
        end
        if (instr_valid && instr_ready && !redirect) begin
            del_pc.push_back(instr_pc);
            del_ins.push_back(instr);
            del_cyc.push_back(32'(cyc));
        end
        cyc++;
        @(posedge clk);
    endtask

    initial begin
        // Streaming with gnt=1 and one-cycle responses
        do_reset();
        clear_logs();
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t1_iss0", qv(iss_addr, 0), 32'h0);
        chk("t1_iss1", qv(iss_addr, 1), 32'h4);
        chk("t1_iss2", qv(iss_addr, 2), 32'h8);
        chk("t1_iss3", qv(iss_addr, 3), 32'hC);
        chk("t1_del0", qv(del_pc, 0), 32'h0);
        chk("t1_del1", qv(del_pc, 1), 32'h4);
        chk("t1_del2", qv(del_pc, 2), 32'h8);
        chk("t1_del3", qv(del_pc, 3), 32'hC);
        chk("t1_ins0", qv(del_ins, 0), 32'hA000_0000);
        chk("t1_ins3", qv(del_ins, 3), 32'hA000_000C);
        chk("t1_lat", qv(del_cyc, 0) - qv(iss_cyc, 0), 32'd2);
        chk("t1_b2b", qv(del_cyc, 3) - qv(del_cyc, 0), 32'd3);

        // Decoder stalled: credit stops fetch at four
        do_reset();
        clear_logs();
        repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("t2_niss", 32'(iss_addr.size()), 32'd4);
        chk("t2_iss3", qv(iss_addr, 3), 32'hC);
        chk("t2_req_off", 32'(last_req), 32'd0);
        chk("t2_valid", 32'(last_valid), 32'd1);
        chk("t2_ndel", 32'(del_pc.size()), 32'd0);
        repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t2_del0", qv(del_pc, 0), 32'h0);
        chk("t2_del1", qv(del_pc, 1), 32'h4);
        chk("t2_del2", qv(del_pc, 2), 32'h8);
        chk("t2_del3", qv(del_pc, 3), 32'hC);
        chk("t2_del4", qv(del_pc, 4), 32'h10);
        chk("t2_iss4", qv(iss_addr, 4), 32'h10);

        // Grant withheld at 0x8
        do_reset();
        clear_logs();
        repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            chk("t3_stall_req", 32'(last_req), 32'd1);
            chk("t3_stall_addr", last_addr, 32'h8);
        end
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t3_iss2", qv(iss_addr, 2), 32'h8);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t3_next_addr", last_addr, 32'hC);
        repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t3_del2", qv(del_pc, 2), 32'h8);

        // Redirect to unaligned 0x13 with two responses held back
        do_reset();
        clear_logs();
        resp_en = 1'b0;
        repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h13);
        chk("t4_redir_req", 32'(last_req), 32'd0);
        resp_en = 1'b1;
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t4_iss2", qv(iss_addr, 2), 32'h10);
        chk("t4_iss3", qv(iss_addr, 3), 32'h14);
        chk("t4_del0", qv(del_pc, 0), 32'h10);
        chk("t4_ins0", qv(del_ins, 0), 32'hA000_0010);

        // Redirect in the same cycle as a response, one more still in flight
        do_reset();
        clear_logs();
        repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
        resp_en = 1'b0;
        step(1'b1, 1'b1, 1'b0, 32'h0);
        resp_en = 1'b1;
        rcyc = cyc;
        step(1'b1, 1'b1, 1'b1, 32'h100);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t5_flushed", 32'(last_valid), 32'd0);
        repeat (5) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t5_iss4", qv(iss_addr, 4), 32'h100);
        chk("t5_del2", qv(del_pc, 2), 32'h100);
        chk("t5_ins2", qv(del_ins, 2), 32'hA000_0100);
        chk("t5_lat", qv(del_cyc, 2) - 32'(rcyc), 32'd3);

        // Reset with buffered words and requests in flight
        do_reset();
        clear_logs();
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
        resp_en = 1'b0;
        repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("t6_pre_valid", 32'(last_valid), 32'd1);
        chk("t6_pre_req", 32'(last_req), 32'd0);
        do_reset();
        clear_logs();
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t6_req", 32'(last_req), 32'd1);
        chk("t6_addr", last_addr, 32'h0);
        repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t6_del0", qv(del_pc, 0), 32'h0);
        chk("t6_ins0", qv(del_ins, 0), 32'hA000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
